mem_port_arbiter: RTL and testbench

- Shares the core's single memory port between instruction fetch (IF) and load/store unit (LSU).
- Request/grant/rvalid handshake on each side. One outstanding transaction at a time.
- LSU has priority. A fairness counter stops fetch starvation.
- Sits between the fetch stage/LSU and the external memory fabric. Gives the controller the LSU done/err inputs it needs for multi-cycle ops.

---
 rtl/mem_port_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and the LSU, one outstanding transaction.
// Optional watchdog on stalled grant/response waits is enabled by defining BUS_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned LSU_MAX_CONSEC = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic              if_err_o,
    input  logic              lsu_req_i,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic              lsu_we_i,
    input  logic [3:0]        lsu_be_i,
    input  logic [31:0]       lsu_wdata_i,
    output logic              lsu_gnt_o,
    output logic              lsu_rvalid_o,
    output logic              lsu_err_o,
    output logic [31:0]       rdata_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic              mem_err_i,
    input  logic [31:0]       mem_rdata_i,
    output logic              busy_o
);

    localparam int unsigned CNT_W = (LSU_MAX_CONSEC == 0) ? 1 : $clog2(LSU_MAX_CONSEC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LSU_MAX_CONSEC);

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned TMR_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID, ABORT} state_e;

    logic [TMR_W-1:0] timer_q, timer_d;
`else
    typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID} state_e;

    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    state_e           state_q, state_d;
    logic             owner_lsu_q, owner_lsu_d;
    logic [CNT_W-1:0] consec_q, consec_d;
    logic             cur_lsu;
    logic             gnt;
    logic             rsp_valid;
    logic             rsp_err;

    // State, owner, fairness counter and watchdog registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_lsu_q <= 1'b0;
            consec_q    <= '0;
`ifdef BUS_TIMEOUT_EN
            timer_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            owner_lsu_q <= owner_lsu_d;
            consec_q    <= consec_d;
`ifdef BUS_TIMEOUT_EN
            timer_q     <= timer_d;
`endif
        end
    end

    // Next-state, arbitration and handshake outputs
    always_comb begin
        state_d     = state_q;
        owner_lsu_d = owner_lsu_q;
        consec_d    = consec_q;
        cur_lsu     = owner_lsu_q;
        mem_req_o   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_err     = 1'b0;
`ifdef BUS_TIMEOUT_EN
        timer_d     = timer_q;
`endif

        case (state_q)
            IDLE: begin
                // IF wins a contended cycle once the LSU has used up its consecutive budget
                cur_lsu = lsu_req_i & (~if_req_i | (consec_q != CNT_MAX));
                if (rst_n && (if_req_i || lsu_req_i)) begin
                    mem_req_o   = 1'b1;
                    owner_lsu_d = cur_lsu;
                    state_d     = mem_gnt_i ? WAIT_RVALID : WAIT_GNT;
`ifdef BUS_TIMEOUT_EN
                    timer_d     = '0;
`endif
                end
            end
            WAIT_GNT: begin
                mem_req_o = 1'b1;
                if (mem_gnt_i) begin
                    state_d = WAIT_RVALID;
`ifdef BUS_TIMEOUT_EN
                    timer_d = '0;
                end else if (timer_q == TMR_MAX) begin
                    rsp_valid = 1'b1;
                    rsp_err   = 1'b1;
                    state_d   = IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
`endif
                end
            end
            WAIT_RVALID: begin
                if (mem_rvalid_i) begin
                    rsp_valid = 1'b1;
                    rsp_err   = mem_err_i;
                    state_d   = IDLE;
`ifdef BUS_TIMEOUT_EN
                end else if (timer_q == TMR_MAX) begin
                    rsp_valid = 1'b1;
                    rsp_err   = 1'b1;
                    state_d   = ABORT;
                    timer_d   = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
`endif
                end
            end
`ifdef BUS_TIMEOUT_EN
            ABORT: begin
                // Wait out a late response so it cannot be mistaken for the next transaction's
                if (mem_rvalid_i || (timer_q == TMR_MAX)) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        gnt       = mem_gnt_i & mem_req_o;
        if_gnt_o  = gnt & ~cur_lsu;
        lsu_gnt_o = gnt & cur_lsu;

        if (lsu_gnt_o) begin
            if (if_req_i) begin
                consec_d = (consec_q == CNT_MAX) ? consec_q : consec_q + CNT_W'(1);
            end else begin
                consec_d = '0;
            end
        end else if (if_gnt_o) begin
            consec_d = '0;
        end

        if_rvalid_o  = rsp_valid & ~owner_lsu_q;
        if_err_o     = rsp_err & ~owner_lsu_q;
        lsu_rvalid_o = rsp_valid & owner_lsu_q;
        lsu_err_o    = rsp_err & owner_lsu_q;

        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_wdata_o = 32'h0;
        if (mem_req_o) begin
            mem_addr_o  = cur_lsu ? lsu_addr_i : if_addr_i;
            mem_we_o    = cur_lsu & lsu_we_i;
            mem_be_o    = cur_lsu ? lsu_be_i : 4'hF;
            mem_wdata_o = cur_lsu ? lsu_wdata_i : 32'h0;
        end
    end

    assign rdata_o = mem_rdata_i;
    assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned MAXC   = 4;
    localparam int unsigned TMO    = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              if_req_i = 1'b0;
    logic [ADDR_W-1:0] if_addr_i = '0;
    logic              if_gnt_o, if_rvalid_o, if_err_o;
    logic              lsu_req_i = 1'b0;
    logic [ADDR_W-1:0] lsu_addr_i = '0;
    logic              lsu_we_i = 1'b0;
    logic [3:0]        lsu_be_i = '0;
    logic [31:0]       lsu_wdata_i = '0;
    logic              lsu_gnt_o, lsu_rvalid_o, lsu_err_o;
    logic [31:0]       rdata_o;
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_we_o;
    logic [3:0]        mem_be_o;
    logic [31:0]       mem_wdata_o;
    logic              mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0, mem_err_i = 1'b0;
    logic [31:0]       mem_rdata_i = '0;
    logic              busy_o;

    int checks = 0;
    int failures = 0;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .LSU_MAX_CONSEC(MAXC), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_err_o(if_err_o),
        .lsu_req_i(lsu_req_i), .lsu_addr_i(lsu_addr_i), .lsu_we_i(lsu_we_i),
        .lsu_be_i(lsu_be_i), .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(lsu_gnt_o),
        .lsu_rvalid_o(lsu_rvalid_o), .lsu_err_o(lsu_err_o), .rdata_o(rdata_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_err_i(mem_err_i),
        .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        if_req_i = 1'b0; lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_be_i = 4'h0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
    endtask

    task automatic check_all_quiet(input string tag);
        check({tag, "_gnt"}, 64'({if_gnt_o, lsu_gnt_o}), 64'(0));
        check({tag, "_rvalid"}, 64'({if_rvalid_o, lsu_rvalid_o, if_err_o, lsu_err_o}), 64'(0));
        check({tag, "_memreq"}, 64'(mem_req_o), 64'(0));
        check({tag, "_memaddr"}, 64'(mem_addr_o), 64'(0));
        check({tag, "_busy"}, 64'(busy_o), 64'(0));
    endtask

    // Transaction-level reference: pending-lock, outstanding flag, owner and LSU streak length
    bit          m_wait, m_busy, m_owner_lsu;
    int          m_consec;
    int          m_age;
    bit          if_pend, lsu_pend;
    logic [31:0] if_a, lsu_a, lsu_wd;
    logic        lsu_w;
    logic [3:0]  lsu_b;

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        logic [9:0] exp_order;
        int         ng;
        int         seen;

        // Reset values while held in reset, with requests present
        idle_inputs();
        if_req_i = 1'b1; lsu_req_i = 1'b1; mem_gnt_i = 1'b1;
        repeat (2) @(negedge clk);
        #1 check_all_quiet("reset");
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;

        // IF-only read
        @(negedge clk);
        if_req_i = 1'b1; if_addr_i = 32'h100; mem_gnt_i = 1'b1;
        #1;
        check("if_gnt", 64'(if_gnt_o), 64'(1));
        check("if_memaddr", 64'(mem_addr_o), 64'(32'h100));
        check("if_be_we", 64'({mem_be_o, mem_we_o}), 64'({4'hF, 1'b0}));
        @(negedge clk);
        if_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
        #1;
        check("if_rvalid", 64'({if_rvalid_o, if_err_o, lsu_rvalid_o}), 64'(3'b100));
        check("if_rdata", 64'(rdata_o), 64'(32'hDEADBEEF));
        check("if_busy_wait", 64'(busy_o), 64'(1));
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        #1 check("if_busy_done", 64'(busy_o), 64'(0));

        // LSU write held in WAIT_GNT while IF also requests
        @(negedge clk);
        lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_addr_i = 32'h200; lsu_be_i = 4'b0011;
        lsu_wdata_i = 32'hCAFE0001; if_req_i = 1'b1; if_addr_i = 32'h300; mem_gnt_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("wg_addr", 64'(mem_addr_o), 64'(32'h200));
            check("wg_we_be", 64'({mem_req_o, mem_we_o, mem_be_o}), 64'({1'b1, 1'b1, 4'b0011}));
            check("wg_wdata", 64'(mem_wdata_o), 64'(32'hCAFE0001));
            check("wg_nognt", 64'({if_gnt_o, lsu_gnt_o}), 64'(0));
            @(negedge clk);
        end
        mem_gnt_i = 1'b1;
        #1 check("wg_gnt", 64'({if_gnt_o, lsu_gnt_o, mem_addr_o}), 64'({1'b0, 1'b1, 32'h200}));
        @(negedge clk);
        idle_inputs();
        mem_rvalid_i = 1'b1;
        #1 check("wg_rvalid", 64'({lsu_rvalid_o, if_rvalid_o}), 64'(2'b10));
        @(negedge clk);
        idle_inputs();

        // LSU read with bus error (LSU grant with IF idle also clears the streak)
        lsu_req_i = 1'b1; lsu_addr_i = 32'h400; mem_gnt_i = 1'b1;
        #1 check("err_gnt", 64'(lsu_gnt_o), 64'(1));
        @(negedge clk);
        idle_inputs();
        mem_rvalid_i = 1'b1; mem_err_i = 1'b1;
        #1 check("err_rsp", 64'({lsu_rvalid_o, lsu_err_o, if_rvalid_o}), 64'(3'b110));
        @(negedge clk);
        idle_inputs();
        #1 check("err_after", 64'({busy_o, lsu_rvalid_o, lsu_err_o}), 64'(0));

        // Continuous contention: four LSU grants, then IF
        @(negedge clk);
        exp_order = 10'b1111011110;
        ng = 0;
        if_req_i = 1'b1; lsu_req_i = 1'b1; lsu_we_i = 1'b0; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
        for (int c = 0; c < 40 && ng < 10; c++) begin
            #1;
            if (if_gnt_o || lsu_gnt_o) begin
                check("order", 64'({if_gnt_o, lsu_gnt_o}), exp_order[9-ng] ? 64'(2'b01) : 64'(2'b10));
                ng++;
            end
            @(negedge clk);
        end
        check("order_count", 64'(ng), 64'(10));
        if_req_i = 1'b0; lsu_req_i = 1'b0; mem_gnt_i = 1'b0;
        @(negedge clk);
        idle_inputs();
        #1 check("order_idle", 64'(busy_o), 64'(0));

`ifdef BUS_TIMEOUT_EN
        // Response never arrives: error response after TMO cycles, then ABORT swallows the late rvalid
        @(negedge clk);
        if_req_i = 1'b1; if_addr_i = 32'h500; mem_gnt_i = 1'b1;
        #1 check("tmo_gnt", 64'(if_gnt_o), 64'(1));
        @(negedge clk);
        idle_inputs();
        seen = 0;
        for (int k = 1; k <= 20 && seen == 0; k++) begin
            #1;
            if (if_rvalid_o) begin
                seen = k;
                check("tmo_err", 64'(if_err_o), 64'(1));
            end
            @(negedge clk);
        end
        check("tmo_cycle", 64'(seen), 64'(TMO + 1));
        lsu_req_i = 1'b1; mem_gnt_i = 1'b1;
        #1 check("abort_hold", 64'({lsu_gnt_o, mem_req_o, busy_o}), 64'(3'b001));
        @(negedge clk);
        idle_inputs();
        mem_rvalid_i = 1'b1;
        #1 check("abort_stale", 64'({lsu_rvalid_o, if_rvalid_o, busy_o}), 64'(3'b001));
        @(negedge clk);
        idle_inputs();
        #1 check("abort_exit", 64'(busy_o), 64'(0));
`else
        seen = 0;
`endif

        // Reset while a response is outstanding
        @(negedge clk);
        if_req_i = 1'b1; if_addr_i = 32'h600; mem_gnt_i = 1'b1;
        @(negedge clk);
        lsu_req_i = 1'b1; lsu_addr_i = 32'h700;
        #2 rst_n = 1'b0;
        #1 check_all_quiet("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("midrst_arb", 64'({if_gnt_o, lsu_gnt_o, mem_addr_o}), 64'({1'b0, 1'b1, 32'h700}));
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the reference model
        m_wait = 0; m_busy = 0; m_owner_lsu = 0; m_consec = 0; m_age = 0;
        if_pend = 0; lsu_pend = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            bit          any, cand, e_req, e_gnt, e_rv;
            logic [31:0] rd;
            @(negedge clk);
            if (!if_pend && $urandom_range(0, 2) == 0) begin
                if_pend = 1; if_a = $urandom;
            end
            if (!lsu_pend && $urandom_range(0, 2) == 0) begin
                lsu_pend = 1; lsu_a = $urandom; lsu_wd = $urandom;
                lsu_w = 1'($urandom_range(0, 1)); lsu_b = 4'($urandom_range(0, 15));
            end
            if_req_i = if_pend; if_addr_i = if_a;
            lsu_req_i = lsu_pend; lsu_addr_i = lsu_a; lsu_we_i = lsu_w;
            lsu_be_i = lsu_b; lsu_wdata_i = lsu_wd;
            mem_gnt_i = ($urandom_range(0, 3) != 0) || (m_wait && m_age >= 4);
            mem_rvalid_i = ($urandom_range(0, 1) != 0) || (m_busy && m_age >= 4);
            mem_err_i = ($urandom_range(0, 3) == 0);
            rd = $urandom;
            mem_rdata_i = rd;

            if (m_wait) begin
                any = 1; cand = m_owner_lsu;
            end else if (m_busy) begin
                any = 0; cand = m_owner_lsu;
            end else begin
                any = if_pend || lsu_pend;
                cand = lsu_pend && !(if_pend && m_consec >= int'(MAXC));
            end
            e_req = any;
            e_gnt = e_req && mem_gnt_i;
            e_rv  = m_busy && mem_rvalid_i;

            #1;
            check("r_req", 64'(mem_req_o), 64'(e_req));
            check("r_gnt", 64'({if_gnt_o, lsu_gnt_o}), 64'({e_gnt && !cand, e_gnt && cand}));
            check("r_rsp", 64'({if_rvalid_o, if_err_o, lsu_rvalid_o, lsu_err_o}),
                  64'({e_rv && !m_owner_lsu, e_rv && !m_owner_lsu && mem_err_i,
                       e_rv && m_owner_lsu, e_rv && m_owner_lsu && mem_err_i}));
            check("r_addr", 64'(mem_addr_o), 64'(e_req ? (cand ? lsu_a : if_a) : 32'h0));
            check("r_we_be", 64'({mem_we_o, mem_be_o}),
                  64'(e_req ? (cand ? {lsu_w, lsu_b} : {1'b0, 4'hF}) : 5'h0));
            if (!e_req || cand)
                check("r_wdata", 64'(mem_wdata_o), 64'(e_req ? lsu_wd : 32'h0));
            check("r_rdata", 64'(rdata_o), 64'(rd));
            check("r_busy", 64'(busy_o), 64'(m_wait || m_busy));

            @(posedge clk);
            m_age++;
            if (e_rv) begin
                m_busy = 0; m_age = 0;
            end
            if (e_gnt) begin
                m_busy = 1; m_wait = 0; m_owner_lsu = cand; m_age = 0;
                if (cand) begin
                    m_consec = if_pend ? ((m_consec < int'(MAXC)) ? m_consec + 1 : m_consec) : 0;
                    lsu_pend = 0;
                end else begin
                    m_consec = 0;
                    if_pend = 0;
                end
            end else if (e_req && !m_wait) begin
                m_wait = 1; m_owner_lsu = cand; m_age = 0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
